// File: rtl/regbank_pkg.sv
// Shared types for the reg_bank_slave register bank: FSM states, decode classes, byte-merge helper.
package regbank_pkg;

    localparam int unsigned WORD_BYTES = 4;
    localparam int unsigned ALIGN_W    = $clog2(WORD_BYTES);
    // Wide enough for NUM_CONST + NUM_RW + 1 words at the largest allowed sizes (16 + 16 + 1).
    localparam int unsigned IDX_W      = 6;

    typedef enum logic {
        IDLE,
        RESP
    } state_e;

    typedef enum logic [1:0] {
        CONST,
        RW,
        CNT,
        UNMAPPED
    } dec_class_e;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  sel);
        logic [31:0] merged;
        merged = old_word;
        for (int k = 0; k < WORD_BYTES; k++) begin
            if (sel[k]) begin
                merged[8*k +: 8] = new_word[8*k +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/reg_bank_decode.sv
// Combinational address decoder for reg_bank_slave: maps a byte address to a decode class and
// word index relative to BaseAddr.
module reg_bank_decode
    import regbank_pkg::*;
#(
    parameter logic [31:0] BaseAddr  = 32'h0200_0100,
    parameter int unsigned NUM_CONST = 3,
    parameter int unsigned NUM_RW    = 4
) (
    input  logic [31:0]      i_adr,
    output dec_class_e       o_class,
    output logic [IDX_W-1:0] o_idx
);

    logic [31:0]      w_off;
    logic [29:0]      w_word;

    // Addresses below BaseAddr wrap to huge offsets and fall through to UNMAPPED.
    assign w_off  = i_adr - BaseAddr;
    assign w_word = 30'(w_off >> ALIGN_W);
    assign o_idx  = w_word[IDX_W-1:0];

    always_comb begin
        o_class = UNMAPPED;
        if (i_adr[ALIGN_W-1:0] != '0) begin
            o_class = UNMAPPED;
        end else if (w_word < 30'(NUM_CONST)) begin
            o_class = CONST;
        end else if (w_word < 30'(NUM_CONST + NUM_RW)) begin
            o_class = RW;
        end else if (w_word == 30'(NUM_CONST + NUM_RW)) begin
            o_class = CNT;
        end else begin
            o_class = UNMAPPED;
        end
    end

endmodule

// File: rtl/reg_bank_slave.sv
// Parametrised strobe/ack register bank: constants, byte-writable scratch words, write counter.
// Define REGBANK_ERR_EN to report unmapped/illegal accesses on oERR instead of a silent oACK.
module reg_bank_slave
    import regbank_pkg::*;
#(
    parameter logic [31:0]              BaseAddr   = 32'h0200_0100,
    parameter int unsigned              NUM_CONST  = 3,
    parameter logic [NUM_CONST*32-1:0]  CONST_VALS = {32'hFEDC_BA98, 32'h89AB_CDEF,
                                                      32'h0123_4567},
    parameter int unsigned              NUM_RW     = 4,
    parameter logic [31:0]              RW_RESET   = 32'h0000_0000
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic [31:0] iADR,
    input  logic [31:0] iDAT,
    input  logic [3:0]  iSEL,
    input  logic        iWE,
    input  logic        iSTB,
    output logic [31:0] oDAT,
    output logic        oACK,
    output logic        oERR
);

    state_e           r_state;
    logic             r_ack;
    logic             r_err;
    logic [31:0]      r_dat;
    logic [31:0]      r_rw [NUM_RW];
    logic [31:0]      r_cnt;

    dec_class_e       w_class;
    logic [IDX_W-1:0] w_idx;
    logic [31:0]      w_rdata;
    logic             w_err;
    logic             w_rw_wr;

    reg_bank_decode #(
        .BaseAddr  (BaseAddr),
        .NUM_CONST (NUM_CONST),
        .NUM_RW    (NUM_RW)
    ) u_decode (
        .i_adr   (iADR),
        .o_class (w_class),
        .o_idx   (w_idx)
    );

`ifdef REGBANK_ERR_EN
    assign w_err = (w_class == UNMAPPED) || (iWE && ((w_class == CONST) || (w_class == CNT)));
`else
    assign w_err = 1'b0;
`endif

    assign w_rw_wr = iWE && (w_class == RW);

    // Unmapped reads fall through to 0.
    always_comb begin
        w_rdata = '0;
        unique case (w_class)
            CONST: begin
                for (int i = 0; i < NUM_CONST; i++) begin
                    if (w_idx == IDX_W'(i)) begin
                        w_rdata = CONST_VALS[32*i +: 32];
                    end
                end
            end
            RW: begin
                for (int i = 0; i < NUM_RW; i++) begin
                    if (w_idx == IDX_W'(NUM_CONST + i)) begin
                        w_rdata = r_rw[i];
                    end
                end
            end
            CNT:     w_rdata = r_cnt;
            default: w_rdata = '0;
        endcase
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            r_state <= IDLE;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_dat   <= '0;
            r_cnt   <= '0;
            for (int i = 0; i < NUM_RW; i++) begin
                r_rw[i] <= RW_RESET;
            end
        end else begin
            case (r_state)
                IDLE: begin
                    r_ack <= 1'b0;
                    r_err <= 1'b0;
                    r_dat <= '0;
                    if (iSTB) begin
                        r_state <= RESP;
                        r_ack   <= !w_err;
                        r_err   <= w_err;
                        r_dat   <= (!iWE && !w_err) ? w_rdata : 32'h0;
                        // A zero byte-enable write still counts as an accepted write.
                        if (w_rw_wr) begin
                            r_cnt <= r_cnt + 32'd1;
                            for (int i = 0; i < NUM_RW; i++) begin
                                if (w_idx == IDX_W'(NUM_CONST + i)) begin
                                    r_rw[i] <= merge_bytes(r_rw[i], iDAT, iSEL);
                                end
                            end
                        end
                    end
                end
                RESP: begin
                    r_state <= IDLE;
                    r_ack   <= 1'b0;
                    r_err   <= 1'b0;
                    r_dat   <= '0;
                end
                default: begin
                    r_state <= IDLE;
                    r_ack   <= 1'b0;
                    r_err   <= 1'b0;
                    r_dat   <= '0;
                end
            endcase
        end
    end

    assign oACK = r_ack;
    assign oERR = r_err;
    assign oDAT = r_dat;

endmodule

// File: tb/tb_reg_bank_slave.sv
// Directed scoreboard bench for reg_bank_slave (default parameters, either REGBANK_ERR_EN setting).
module tb_reg_bank_slave;

    localparam logic [31:0] BASE  = 32'h0200_0100;
    localparam logic [95:0] CVALS = {32'hFEDC_BA98, 32'h89AB_CDEF, 32'h0123_4567};
`ifdef REGBANK_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    typedef struct packed {
        logic        ack;
        logic        err;
        logic [31:0] dat;
    } resp_t;

    logic        iCLK = 1'b0;
    logic        iRST;
    logic [31:0] iADR;
    logic [31:0] iDAT;
    logic [3:0]  iSEL;
    logic        iWE;
    logic        iSTB;
    logic [31:0] oDAT;
    logic        oACK;
    logic        oERR;

    int          n_chk = 0;
    int          n_err = 0;
    logic [31:0] m_rw [4];
    logic [31:0] m_cnt;
    resp_t       sb_q [$];

    reg_bank_slave dut (
        .iCLK (iCLK),
        .iRST (iRST),
        .iADR (iADR),
        .iDAT (iDAT),
        .iSEL (iSEL),
        .iWE  (iWE),
        .iSTB (iSTB),
        .oDAT (oDAT),
        .oACK (oACK),
        .oERR (oERR)
    );

    always #5 iCLK = ~iCLK;

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Reference model: computes the expected response and applies write side effects.
    task automatic model(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, output resp_t r);
        logic [31:0] off;
        logic [95:0] cv;
        int          wi;
        logic        mapped;
        logic        bad;
        off    = adr - BASE;
        wi     = int'(off >> 2);
        cv     = CVALS;
        mapped = (adr[1:0] == 2'b00) && (off < 32'd32);
        bad    = !mapped || (we && (wi < 3 || wi == 7));
        r      = '0;
        if (bad) begin
            r.ack = !ERR_EN;
            r.err = ERR_EN;
        end else begin
            r.ack = 1'b1;
            if (we) begin
                for (int k = 0; k < 4; k++) begin
                    if (sel[k]) m_rw[wi-3][8*k +: 8] = dat[8*k +: 8];
                end
                m_cnt = m_cnt + 32'd1;
            end else if (wi < 3) begin
                r.dat = cv[wi*32 +: 32];
            end else if (wi < 7) begin
                r.dat = m_rw[wi-3];
            end else begin
                r.dat = m_cnt;
            end
        end
    endtask

    task automatic wait_resp(input string tag);
        resp_t e;
        int    n;
        n = 0;
        do begin
            @(posedge iCLK);
            #1;
            n++;
        end while (!(oACK || oERR) && n < 8);
        n_chk++;
        assert (oACK || oERR) else begin
            n_err++;
            $error("FAIL %s completion: observed none after %0d cycles, expected ack or err", tag, n);
        end
        e = sb_q.pop_front();
        if (oACK || oERR) begin
            check1({tag, " ack"}, oACK, e.ack);
            check1({tag, " err"}, oERR, e.err);
            check32({tag, " dat"}, oDAT, e.dat);
            check1({tag, " latency"}, n == 1, 1'b1);
        end
    endtask

    task automatic xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel, input string tag);
        resp_t e;
        model(we, adr, dat, sel, e);
        sb_q.push_back(e);
        @(negedge iCLK);
        iSTB = 1'b1;
        iWE  = we;
        iADR = adr;
        iDAT = dat;
        iSEL = sel;
        wait_resp(tag);
        iSTB = 1'b0;
        @(posedge iCLK);
        #1;
        check1({tag, " idle ack"}, oACK, 1'b0);
        check1({tag, " idle err"}, oERR, 1'b0);
        check32({tag, " idle dat"}, oDAT, 32'h0);
    endtask

    initial begin
        int pulses;
        iRST = 1'b1;
        iSTB = 1'b0;
        iWE  = 1'b0;
        iADR = '0;
        iDAT = '0;
        iSEL = '0;
        for (int i = 0; i < 4; i++) m_rw[i] = 32'h0;
        m_cnt = 32'h0;
        repeat (2) @(posedge iCLK);
        #1;
        check1("reset ack", oACK, 1'b0);
        check1("reset err", oERR, 1'b0);
        check32("reset dat", oDAT, 32'h0);
        @(negedge iCLK);
        iRST = 1'b0;

        xfer(1'b0, BASE + 32'h0, 32'h0, 4'h0, "rd const0");
        xfer(1'b0, BASE + 32'h4, 32'h0, 4'h0, "rd const1");
        xfer(1'b0, BASE + 32'h8, 32'h0, 4'h0, "rd const2");

        xfer(1'b1, BASE + 32'hC,  32'hDEAD_BEEF, 4'b0101, "wr scr0 sel0101");
        xfer(1'b0, BASE + 32'hC,  32'h0, 4'h0, "rd scr0");
        xfer(1'b0, BASE + 32'h1C, 32'h0, 4'h0, "rd cnt1");
        xfer(1'b1, BASE + 32'h18, 32'h1234_5678, 4'hF, "wr scr3 full");
        xfer(1'b1, BASE + 32'h10, 32'hFFFF_FFFF, 4'h0, "wr scr1 sel0");
        xfer(1'b0, BASE + 32'h10, 32'h0, 4'h0, "rd scr1");
        xfer(1'b0, BASE + 32'h18, 32'h0, 4'h0, "rd scr3");
        xfer(1'b0, BASE + 32'h1C, 32'h0, 4'h0, "rd cnt3");

        xfer(1'b1, BASE + 32'h4,  32'h5555_AAAA, 4'hF, "wr const1");
        xfer(1'b0, BASE + 32'h4,  32'h0, 4'h0, "rd const1 kept");
        xfer(1'b0, BASE + 32'h20, 32'h0, 4'h0, "rd past end");
        xfer(1'b0, BASE + 32'h2,  32'h0, 4'h0, "rd misaligned");
        xfer(1'b0, BASE - 32'h4,  32'h0, 4'h0, "rd below base");
        xfer(1'b1, BASE + 32'h1C, 32'h0000_0099, 4'hF, "wr cnt");
        xfer(1'b0, BASE + 32'h1C, 32'h0, 4'h0, "rd cnt kept");

        // Strobe held for 6 cycles: captures on alternate edges only.
        pulses = 0;
        @(negedge iCLK);
        iSTB = 1'b1;
        iWE  = 1'b0;
        iADR = BASE + 32'h4;
        for (int i = 0; i < 6; i++) begin
            @(posedge iCLK);
            #1;
            if (oACK) pulses++;
            check1("hold ack", oACK, (i % 2) == 0);
            check32("hold dat", oDAT, ((i % 2) == 0) ? 32'h89AB_CDEF : 32'h0);
        end
        iSTB = 1'b0;
        check32("hold pulses", 32'(pulses), 32'd3);

        @(negedge iCLK);
        force dut.r_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.r_cnt;
        m_cnt = 32'hFFFF_FFFF;
        xfer(1'b0, BASE + 32'h1C, 32'h0, 4'h0, "rd cnt max");
        xfer(1'b1, BASE + 32'h14, 32'hAABB_CCDD, 4'hF, "wr scr2 wrap");
        xfer(1'b0, BASE + 32'h1C, 32'h0, 4'h0, "rd cnt wrapped");
        xfer(1'b0, BASE + 32'h14, 32'h0, 4'h0, "rd scr2");

        // Reset asserted while the response is on the bus.
        @(negedge iCLK);
        iSTB = 1'b1;
        iWE  = 1'b0;
        iADR = BASE + 32'h14;
        @(posedge iCLK);
        #1;
        check1("pre-rst ack", oACK, 1'b1);
        check32("pre-rst dat", oDAT, 32'hAABB_CCDD);
        #2;
        iRST = 1'b1;
        #1;
        check1("mid-rst ack", oACK, 1'b0);
        check1("mid-rst err", oERR, 1'b0);
        check32("mid-rst dat", oDAT, 32'h0);
        iSTB = 1'b0;
        for (int i = 0; i < 4; i++) m_rw[i] = 32'h0;
        m_cnt = 32'h0;
        @(negedge iCLK);
        iRST = 1'b0;
        xfer(1'b0, BASE + 32'h14, 32'h0, 4'h0, "rd scr2 after rst");
        xfer(1'b0, BASE + 32'hC,  32'h0, 4'h0, "rd scr0 after rst");
        xfer(1'b0, BASE + 32'h1C, 32'h0, 4'h0, "rd cnt after rst");
        xfer(1'b0, BASE + 32'h8,  32'h0, 4'h0, "rd const2 after rst");

        check32("scoreboard drained", 32'(sb_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout, expected bench completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/reg_bank_slave.md
# reg_bank_slave

Parametrised memory-mapped register bank on the simple strobe/ack slave bus, successor to the fixed three-constant ID block. It holds NUM_CONST read-only constant words, NUM_RW byte-writable scratch registers and one read-only write-counter word, all at consecutive word addresses from BaseAddr. The acknowledge and read data are registered with one cycle of latency. It sits on the peripheral bus next to other slaves and drives 0 on oDAT when idle; it never drives high impedance.

## Interface
- BaseAddr, 32'h0200_0100, word-aligned base of the window
- NUM_CONST, 3, number of read-only constant words (1..16)
- CONST_VALS, {32'hFEDC_BA98, 32'h89AB_CDEF, 32'h0123_4567}, packed NUM_CONST*32 vector; word i is bits [32i+31:32i]
- NUM_RW, 4, number of read/write scratch words (1..16)
- RW_RESET, 32'h0000_0000, reset value of every scratch word
- iCLK  in  1  clock; all state updates on the rising edge
- iRST  in  1  reset; asynchronous, active-high
- iADR  in  32  byte address
- iDAT  in  32  write data
- iSEL  in  4  byte enables for writes; bit k covers bits [8k+7:8k]
- iWE  in  1  1 = write, 0 = read
- iSTB  in  1  transfer request, active high
- oDAT  out  32  read data, valid only while oACK = 1, otherwise 0
- oACK  out  1  transfer completion, single-cycle pulse
- oERR  out  1  error completion, single-cycle pulse (see Configuration)

## Operation
- Map: word index w = (iADR − BaseAddr) >> 2.
  - w in 0..NUM_CONST−1: constants.
  - w in NUM_CONST..NUM_CONST+NUM_RW−1: scratch words.
  - w = NUM_CONST+NUM_RW: counter, read-only.
  - Any other address, and any address with iADR[1:0] ≠ 0, is unmapped.
- FSM states:
  - IDLE → RESP when iSTB = 1. The request is captured on this edge.
  - RESP → IDLE unconditionally.
  - Throughput: one transfer per 2 cycles. If iSTB stays high through RESP, a new transfer is captured on the next IDLE cycle.
- Capture edge (IDLE with iSTB = 1):
  - Read of a mapped word: oDAT is loaded from the selected word.
  - Write to a scratch word: only enabled bytes are updated; iSEL = 0 completes with no change.
  - Every accepted scratch write increments the counter, including iSEL = 0.
- Counter: 32 bits, wraps FFFF_FFFF → 0000_0000.
- Writes to constants or to the counter: no state change and no counter increment.
- Bus signals are ignored in RESP; a request changing during RESP has no effect.
- Reset values: oACK = 0, oERR = 0, oDAT = 0, FSM = IDLE, scratch words = RW_RESET, counter = 0.

## Timing
- Request sampled at edge N. oACK or oERR is high for exactly cycle N..N+1, with oDAT valid in the same cycle. Both return to 0 at edge N+1.
- oACK and oERR are never high together.
- Write data is visible to a read captured at edge N+2 or later.
- iRST asserted mid-transfer clears oACK, oERR and oDAT asynchronously. The transfer is lost and any captured write has already taken effect only if its capture edge preceded the reset.
- The master must hold iSTB/iADR/iWE/iDAT/iSEL stable until it sees the completion, then either drop iSTB or present the next request.

## Configuration
- REGBANK_ERR_EN defined:
  - Unmapped accesses, and writes to constants or to the counter, complete with oERR = 1, oACK = 0 and oDAT = 0.
- REGBANK_ERR_EN undefined:
  - The same accesses complete with oACK = 1. Reads return 0 and writes are dropped.
  - oERR is tied to 0.

## Structure
- Package regbank_pkg: FSM state enum (IDLE, RESP), WORD_BYTES = 4, a decode-class enum (CONST, RW, CNT, UNMAPPED).
- Sub-module reg_bank_decode: combinational address decoder producing the decode class and word index from iADR, BaseAddr, NUM_CONST and NUM_RW. The top level holds the FSM, the storage and the response registers.

## Test plan
- Reset, then read BaseAddr+0/+4/+8 with default parameters → oACK one cycle after capture with oDAT = 0123_4567, 89AB_CDEF, FEDC_BA98. Between transfers, oDAT = 0.
- Write DEAD_BEEF with iSEL = 4'b0101 to BaseAddr+0xC, then read it back → 00AD_00EF. Counter read at BaseAddr+0x1C → 0000_0001.
- Hold iSTB high for 6 cycles on a read → exactly 3 oACK pulses, each followed by a low cycle.
- Write to BaseAddr+0x4, and read BaseAddr+0x20 and BaseAddr+0x2 → with REGBANK_ERR_EN: oERR pulses and oDAT = 0. Without it: oACK pulses and the constant is unchanged.
- Preload the counter path with FFFF_FFFF scratch writes, or force the counter to FFFF_FFFF, then do one write → counter reads 0000_0000.
- Assert iRST during the RESP cycle → oACK drops immediately. Scratch words return to RW_RESET and the counter to 0; the next read works normally.
